stream_demux1to4: RTL and testbench

- 1-to-4 stream demultiplexer; the inverse of the team's 4:1 mux tree. Routes one valid/ready input stream to one of four output channels, chosen per beat by a 2-bit select.
- Each output channel has a one-entry output register. Back-pressure on one channel does not corrupt or stall data already held in the other channels.
- Sits between a single producer and four independent consumers in the datapath.

---
 rtl/stream_demux1to4.sv | 117 +++++++++++
 tb/tb_stream_demux1to4.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux1to4.sv
// stream_demux1to4 -- 1-to-4 valid/ready stream demultiplexer.
//
// Routes each input beat to one of four output channels selected per beat by
// in_sel. Every channel owns a one-entry output register, so a stalled
// consumer only blocks input beats aimed at its own channel. Beats already
// held in the other channels keep draining independently.
//
// Ports:
//   clk        rising-edge clock, the only clock
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept the beat this cycle (comb. from in_sel/out_ready)
//   in_data    input payload, DATA_W bits
//   in_sel     destination channel 0..3
//   out_valid  bit i: channel i holds a beat
//   out_ready  bit i: consumer i accepts this cycle
//   out_data   channel i payload at [i*DATA_W +: DATA_W]
//   cnt_flat   (only with STREAM_DEMUX_CNT_EN) four saturating 16-bit
//              delivered-beat counters, counter i at [i*16 +: 16]
//
// Optional feature macro: STREAM_DEMUX_CNT_EN

module stream_demux1to4 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            in_sel,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
`ifdef STREAM_DEMUX_CNT_EN
    output logic [63:0]           cnt_flat,
`endif
    output logic [4*DATA_W-1:0]   out_data
);

    logic [3:0]        full_q;
    logic [3:0]        full_d;
    logic [DATA_W-1:0] buf_q [4];
    logic [3:0]        load;
    logic [3:0]        drain;
    logic              in_fire;

    // A full channel can still take a beat when its consumer drains on the same
    // edge, giving one beat per cycle per channel. in_valid is not used here so
    // the ready path never loops back through the source.
    always_comb begin
        in_ready = ~full_q[in_sel] | out_ready[in_sel];
        in_fire  = in_valid & in_ready;
    end

    always_comb begin
        load  = 4'b0000;
        drain = full_q & out_ready;
        for (int i = 0; i < 4; i++) begin
            if (in_fire && (in_sel == 2'(i))) begin
                load[i] = 1'b1;
            end
        end
        // Load wins over drain: the old beat leaves, the new one takes its place.
        full_d = load | (full_q & ~drain);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    buf_q[i] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_valid = full_q;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*DATA_W +: DATA_W] = buf_q[i];
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0] cnt_q [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Saturate rather than wrap so a stuck-high count is obvious.
                if (drain[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_flat[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux1to4.sv
// Directed self-checking bench for stream_demux1to4.
module tb_stream_demux1to4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [63:0] cnt_flat;
`endif

    int errors = 0;
    int checks = 0;

    stream_demux1to4 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STREAM_DEMUX_CNT_EN
        .cnt_flat  (cnt_flat),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_valid(input string name, input logic [3:0] exp);
        checks++;
        if (out_valid !== exp) begin
            errors++;
            $display("FAIL %s: out_valid got %b want %b", name, out_valid, exp);
        end
    endtask

    task automatic chk_data(input string name, input int ch, input logic [7:0] exp);
        logic [7:0] got;
        got = out_data[ch*8 +: 8];
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: ch%0d data got %h want %h", name, ch, got, exp);
        end
    endtask

    task automatic chk_ready(input string name, input logic exp);
        checks++;
        if (in_ready !== exp) begin
            errors++;
            $display("FAIL %s: in_ready got %b want %b", name, in_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'd1; out_ready = 4'b0000;
        tick();
        tick();
        chk_valid("reset_valid", 4'b0000);
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want %h", out_data, 32'h0);
        end
        chk_ready("reset_ready_in_reset", 1'b1);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk_ready("reset_ready_after", 1'b1);
        tick();
        chk_valid("reset_no_load", 4'b0000);
    endtask

    task automatic test_routing();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] ohs  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = vals[k]; in_sel = 2'(k);
            #1;
            chk_ready("route_ready", 1'b1);
            tick();
            chk_valid("route_valid", ohs[k]);
            chk_data("route_data", k, vals[k]);
        end
        in_valid = 1'b0;
        tick();
        chk_valid("route_drained", 4'b0000);
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1011;
        in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2;
        tick();
        chk_valid("bp_first_valid", 4'b0100);
        chk_data("bp_first_data", 2, 8'hA5);
        in_data = 8'h5A;
        #1;
        chk_ready("bp_stall", 1'b0);
        tick();
        chk_valid("bp_hold_valid", 4'b0100);
        chk_data("bp_hold_data", 2, 8'hA5);
        out_ready = 4'b1111;
        #1;
        chk_ready("bp_release", 1'b1);
        tick();
        chk_valid("bp_second_valid", 4'b0100);
        chk_data("bp_second_data", 2, 8'h5A);
        in_valid = 1'b0;
        tick();
        chk_valid("bp_drained", 4'b0000);
    endtask

    task automatic test_isolation();
        out_ready = 4'b1101;
        in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd1;
        tick();
        chk_valid("iso_ch1_loaded", 4'b0010);
        in_data = 8'h77; in_sel = 2'd3;
        #1;
        chk_ready("iso_ready_ch3", 1'b1);
        tick();
        chk_valid("iso_both", 4'b1010);
        chk_data("iso_ch3_data", 3, 8'h77);
        chk_data("iso_ch1_held", 1, 8'h3C);
        in_valid = 1'b0;
        tick();
        chk_valid("iso_ch3_gone", 4'b0010);
        chk_data("iso_ch1_still", 1, 8'h3C);
        out_ready = 4'b1111;
        tick();
        chk_valid("iso_drained", 4'b0000);
    endtask

    task automatic test_throughput();
        out_ready = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 8'(k); in_sel = 2'd0;
            #1;
            chk_ready("tp_ready", 1'b1);
            tick();
            chk_valid("tp_valid", 4'b0001);
            chk_data("tp_data", 0, 8'(k));
        end
        in_valid = 1'b0;
        tick();
        chk_valid("tp_drained", 4'b0000);
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'h99; in_sel = 2'd1;
        tick();
        chk_valid("mid_loaded", 4'b0010);
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        chk_valid("mid_reset_valid", 4'b0000);
        chk_data("mid_reset_data", 1, 8'h00);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef STREAM_DEMUX_CNT_EN
    task automatic test_counters();
        logic [1:0] sels [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 4'b1111;
        tick();
        rst_n = 1'b1;
        checks++;
        if (cnt_flat !== 64'h0) begin
            errors++;
            $display("FAIL cnt_reset: got %h want %h", cnt_flat, 64'h0);
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'(k + 1); in_sel = sels[k];
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (cnt_flat !== {16'd0, 16'd1, 16'd0, 16'd3}) begin
            errors++;
            $display("FAIL cnt_values: got %h want %h", cnt_flat,
                     {16'd0, 16'd1, 16'd0, 16'd3});
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'b0000;
        #1;
        test_reset();
        test_routing();
        test_backpressure();
        test_isolation();
        test_throughput();
        test_reset_mid();
`ifdef STREAM_DEMUX_CNT_EN
        test_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
